aes_iter_cipher: RTL and testbench
==================================

# aes_iter_cipher

Iterative, parametrised AES datapath that replaces the fully unrolled one-direction pipeline with a single round engine reused over Nr rounds. It supports AES-128/192/256 and runtime encrypt/decrypt selection. The block sits between the key-expansion block, which supplies the expanded schedule, and the block-mode/DMA layer, which moves data over valid/ready handshakes. RPC rounds are unrolled per cycle, which trades area against latency.

## Interface
- Nk, default 4: key words; legal values are 4, 6 and 8.
- Nr, default Nk+6: number of rounds.
- RPC, default 1: rounds per clock. It must divide Nr; any other value is an elaboration error.
- TAG_W, default 4: width of the sideband tag, which passes through unchanged.
- clk, input, 1: clock. All flops are rising-edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- k_sch, input, 128 x [0:Nr]: expanded key schedule. It must be held stable from accept until the output is consumed.
- flush, input, 1: synchronous abort. It drops the block in flight.
- in_valid, input, 1: input block valid.
- in_ready, output, 1: block can accept input.
- in_decrypt, input, 1: mode select. 1 selects the inverse cipher (FIPS-197 5.3); 0 selects the cipher (5.1).
- in_data, input, 128: plaintext or ciphertext.
- in_tag, input, TAG_W: sideband tag.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts the result.
- out_data, output, 128: result.
- out_tag, output, TAG_W: tag captured at accept.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **Reset values:** state = IDLE; out_valid = 0; out_data = 0; out_tag = 0; round counter = 0; in_ready = 1 once reset is released.
- **in_ready** = !flush && (IDLE || (DONE && out_ready)).
- **Accept:** occurs when in_valid && in_ready.
  - state register ← in_data ^ k_sch[in_decrypt ? Nr : 0].
  - mode and tag are latched.
  - rnd ← 0.
  - FSM → RUN.
- **RUN, per cycle:** applies RPC consecutive rounds and sets rnd ← rnd + RPC.
  - Encrypt, round r: SubBytes, ShiftRows, MixColumns (omitted when r = Nr), then AddRoundKey with k_sch[r].
  - Decrypt, round r: InvShiftRows, InvSubBytes, AddRoundKey with k_sch[Nr−r], then InvMixColumns (omitted when r = Nr).
  - When rnd + RPC = Nr: the result is registered into out_data, out_valid ← 1, FSM → DONE.
- **DONE:**
  - out_data, out_tag and out_valid hold until out_ready.
  - out_ready with in_valid: the next block is accepted in the same cycle, FSM → RUN, out_valid ← 0.
  - out_ready without in_valid: FSM → IDLE.
- **flush:** wins over every other event. Next state is IDLE with out_valid = 0. An input presented in the same cycle is not accepted, because in_ready is 0.
- **Reset mid-operation:** the in-flight block is lost and no output is produced.
- **k_sch and in_decrypt changes:** k_sch changes while in RUN give undefined data; this is not checked. in_decrypt is only sampled at accept.

## Timing
- Accept at the edge ending cycle t gives out_valid high from cycle t + Nr/RPC + 1.
  - Nk=4, RPC=1: latency 11 cycles.
  - Nk=8, RPC=2: latency 8 cycles.
- Throughput with out_ready tied high is one block per Nr/RPC + 1 cycles.
- in_ready is combinational from out_ready and flush. out_valid and out_data are registered.
- The critical path is RPC round stages plus the output mux. RPC=1 must close timing at the Nk=4 pipeline's frequency.

## Structure
- **aes.svh functions:** SubBytes, InvSubBytes, ShiftRows, InvShiftRows, MixColumns, InvMixColumns and AddRoundKey all live there. The state enum aes_iter_state_t is added to the same file.
- **aes_round:** one combinational sub-module with inputs state, round key, decrypt and final, and output next state. It is instantiated RPC times in a generate loop.
- **Key-index and final-round selection:** computed per stage from rnd and the stage offset.
- **Flops:** use the DFF_ARN and DFFEN macros from flops.svh.

## Test plan
- **AES-128, FIPS-197 C.1, encrypt.**
  - Stimulus: Nk=4, RPC=1; key 000102…0f; pt 00112233445566778899aabbccddeeff.
  - Required: ct 69c4e0d86a7b0430d8cdb78070b4c55a with out_valid exactly 11 cycles after accept; decrypting the ct returns the pt.
- **AES-192 C.2 and AES-256 C.3, both modes, RPC ∈ {1, 2}.**
  - AES-192 required ct: dda97ca4864cdfe06eaf70a0ec0d7191.
  - AES-256 required ct: 8ea2b7ca516745bfeafc49904b496089.
  - Latency must equal Nr/RPC + 1.
- **Backpressure.**
  - Stimulus: hold out_ready=0 for 20 cycles in DONE.
  - Required: out_data and out_tag stable, in_ready=0, and no second accept.
- **Back-to-back.**
  - Stimulus: out_ready=1, in_valid=1 continuously, alternating encrypt/decrypt, tags 0..7.
  - Required: one result per Nr/RPC + 1 cycles, tags in order, all values correct.
- **Flush.**
  - Stimulus: assert flush in RUN at round 5, together with in_valid.
  - Required: no out_valid, no accept, in_ready=1 next cycle; the next block completes correctly.
- **Async reset.**
  - Stimulus: drop rst_n mid-RUN and mid-DONE.
  - Required: out_valid falls immediately; out_data=0; in_ready=1 after release.

Source files
------------

// File: rtl/aes_iter_cipher_pkg.sv
// Shared types and AES round primitives (FIPS-197) for the iterative cipher.
// Bytes are numbered MSB-first: byte i = row (i % 4), column (i / 4).
package aes_iter_cipher_pkg;

    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } aes_iter_state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Inverse table derived from SBOX; constant-folds to a 256-entry ROM.
    function automatic logic [7:0] inv_sbox_byte(input logic [7:0] b);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 256; i++) begin
            if (SBOX[i] == b) r = 8'(i);
        end
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic aes_block_t sub_bytes(input aes_block_t s);
        aes_block_t r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox_byte(s[127-8*i -: 8]);
        return r;
    endfunction

    function automatic aes_block_t inv_sub_bytes(input aes_block_t s);
        aes_block_t r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv_sbox_byte(s[127-8*i -: 8]);
        return r;
    endfunction

    function automatic aes_block_t shift_rows(input aes_block_t s);
        aes_block_t r;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c+w)%4)) -: 8];
        return r;
    endfunction

    function automatic aes_block_t inv_shift_rows(input aes_block_t s);
        aes_block_t r;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127-8*(w+4*((c+w)%4)) -: 8] = s[127-8*(w+4*c) -: 8];
        return r;
    endfunction

    // Circulant column multiply; m is the first matrix row.
    function automatic aes_block_t mix_cols(input aes_block_t s, input logic [0:3][7:0] m);
        aes_block_t r;
        logic [7:0] acc;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                acc = '0;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(s[127-8*(4*c+j) -: 8], m[(j-k+4)%4]);
                r[127-8*(4*c+k) -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic aes_block_t mix_columns(input aes_block_t s);
        return mix_cols(s, {8'h02, 8'h03, 8'h01, 8'h01});
    endfunction

    function automatic aes_block_t inv_mix_columns(input aes_block_t s);
        return mix_cols(s, {8'h0e, 8'h0b, 8'h0d, 8'h09});
    endfunction

    function automatic aes_block_t add_round_key(input aes_block_t s, input aes_block_t k);
        return s ^ k;
    endfunction

endpackage

// File: rtl/aes_iter_cipher_if.sv
// Block-level valid/ready bus between the block-mode/DMA layer (master) and the cipher (slave).
interface aes_iter_cipher_if #(
    parameter int TAG_W = 4
);
    import aes_iter_cipher_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic             in_decrypt;
    aes_block_t       in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    aes_block_t       out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_decrypt, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_decrypt, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

endinterface

// File: rtl/aes_iter_cipher_round.sv
// One combinational AES round, forward or inverse; the final round skips (Inv)MixColumns.
module aes_iter_cipher_round
    import aes_iter_cipher_pkg::*;
(
    input  aes_block_t state,
    input  aes_block_t round_key,
    input  logic       decrypt,
    input  logic       final_round,
    output aes_block_t next_state
);

    aes_block_t enc_t;
    aes_block_t dec_t;

    always_comb begin
        // NOTE: every variable is written unconditionally before any conditional update, so no latch is inferred.
        enc_t = shift_rows(sub_bytes(state));
        if (!final_round) enc_t = mix_columns(enc_t);
        dec_t = add_round_key(inv_sub_bytes(inv_shift_rows(state)), round_key);
        if (!final_round) dec_t = inv_mix_columns(dec_t);
        next_state = decrypt ? dec_t : add_round_key(enc_t, round_key);
    end

endmodule

// File: rtl/aes_iter_cipher.sv
// Iterative AES-128/192/256 encrypt/decrypt engine running RPC rounds per clock
// over an externally supplied key schedule.
module aes_iter_cipher
    import aes_iter_cipher_pkg::*;
#(
    parameter int Nk    = 4,
    parameter int Nr    = Nk + 6,
    parameter int RPC   = 1,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  aes_block_t       k_sch [0:Nr],
    input  logic             flush,
    aes_iter_cipher_if.slave bus
);

    localparam int RW = $clog2(Nr + 1);

    if (!(Nk == 4 || Nk == 6 || Nk == 8) || (RPC < 1) || ((Nr % RPC) != 0)) begin : g_bad_cfg
        $error("aes_iter_cipher: illegal Nk/Nr/RPC combination");
    end

    aes_iter_state_t  fsm_q;
    aes_block_t       blk_q;
    logic             mode_q;
    logic [TAG_W-1:0] tag_q;
    logic [RW-1:0]    rnd_q;
    aes_block_t       out_data_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_valid_q;

    logic       in_ready;
    logic       accept;
    logic       last_cycle;
    aes_block_t init_key;
    aes_block_t stage_d [0:RPC];

    assign in_ready   = !flush && (fsm_q == IDLE || (fsm_q == DONE && bus.out_ready));
    assign accept     = bus.in_valid && in_ready;
    assign last_cycle = (rnd_q == RW'(Nr - RPC));
    assign init_key   = bus.in_decrypt ? k_sch[Nr] : k_sch[0];

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_tag   = out_tag_q;

    // Stage g applies round rnd+g+1; decrypt walks the schedule from the top.
    assign stage_d[0] = blk_q;
    for (genvar g = 0; g < RPC; g++) begin : g_round
        logic [RW-1:0] r_idx;
        logic [RW-1:0] k_idx;
        logic          last;

        assign r_idx = rnd_q + RW'(g + 1);
        assign k_idx = mode_q ? RW'(Nr) - r_idx : r_idx;
        assign last  = (r_idx == RW'(Nr));

        aes_iter_cipher_round u_round (
            .state       (stage_d[g]),
            .round_key   (k_sch[k_idx]),
            .decrypt     (mode_q),
            .final_round (last),
            .next_state  (stage_d[g+1])
        );
    end

    // NOTE: state is updated with non-blocking assignments only, so every read sees the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            blk_q       <= '0;
            mode_q      <= 1'b0;
            tag_q       <= '0;
            rnd_q       <= '0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            fsm_q       <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            unique case (fsm_q)
                RUN: begin
                    blk_q <= stage_d[RPC];
                    rnd_q <= rnd_q + RW'(RPC);
                    if (last_cycle) begin
                        out_data_q  <= stage_d[RPC];
                        out_tag_q   <= tag_q;
                        out_valid_q <= 1'b1;
                        fsm_q       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        fsm_q       <= IDLE;
                    end
                end
                default: ;
            endcase
            // Accept is only possible in IDLE or a consuming DONE, so it overrides the exit above.
            if (accept) begin
                blk_q  <= add_round_key(bus.in_data, init_key);
                mode_q <= bus.in_decrypt;
                tag_q  <= bus.in_tag;
                rnd_q  <= '0;
                fsm_q  <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_aes_iter_cipher.sv
// Directed bench: FIPS-197 C.1-C.3 vectors on five Nk/RPC configurations, then
// backpressure, back-to-back, flush and async reset on the AES-128 RPC=1 instance.
module tb_aes_iter_cipher;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_B = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_C = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_decrypt = 1'b0;
    logic [3:0]   in_tag = 4'h0;
    logic         out_ready = 1'b0;
    logic [127:0] in_data_c [5];

    logic [4:0]   ov;
    logic [4:0]   ir;
    logic [127:0] od [5];
    logic [3:0]   ot [5];

    logic [127:0] rk [3][15];
    logic [7:0]   tb_sbox [256];
    logic [127:0] ct_exp [5];
    int           lat_exp [5];
    int           first [5];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_cfg
        localparam int NK = (g == 0) ? 4 : (g < 3) ? 6 : 8;
        localparam int RP = (g == 2 || g == 4) ? 2 : 1;
        localparam int KI = (NK - 4) / 2;

        logic [127:0] ks [0:NK+6];
        aes_iter_cipher_if #(.TAG_W(4)) bus ();

        for (genvar j = 0; j <= NK + 6; j++) begin : g_ks
            assign ks[j] = rk[KI][j];
        end

        assign bus.in_valid   = in_valid;
        assign bus.in_decrypt = in_decrypt;
        assign bus.in_data    = in_data_c[g];
        assign bus.in_tag     = in_tag;
        assign bus.out_ready  = out_ready;
        assign ov[g] = bus.out_valid;
        assign ir[g] = bus.in_ready;
        assign od[g] = bus.out_data;
        assign ot[g] = bus.out_tag;

        aes_iter_cipher #(.Nk(NK), .RPC(RP), .TAG_W(4)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .k_sch (ks),
            .flush (flush),
            .bus   (bus)
        );
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {tb_sbox[w[31:24]], tb_sbox[w[23:16]], tb_sbox[w[15:8]], tb_sbox[w[7:0]]};
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (tb_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            tb_sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                         {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand(input int nk, input logic [255:0] key, input int ki);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = tb_mul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < nk + 7; r++) rk[ki][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Call just after a negedge with instance 0 idle; returns at the negedge of cycle t+1.
    task automatic issue(input logic dec, input logic [127:0] d, input logic [3:0] t);
        in_valid   = 1'b1;
        in_decrypt = dec;
        in_tag     = t;
        for (int g = 0; g < 5; g++) in_data_c[g] = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            if (ov[0]) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_all();
        for (int g = 0; g < 5; g++) first[g] = 0;
        for (int c = 1; c <= 40; c++) begin
            for (int g = 0; g < 5; g++)
                if (first[g] == 0 && ov[g]) first[g] = c;
            if (first[0] != 0 && first[1] != 0 && first[2] != 0 && first[3] != 0 && first[4] != 0) break;
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        int nb;
        int nres;
        int last_c;
        int hits;

        ct_exp  = '{CT_A, CT_B, CT_B, CT_C, CT_C};
        lat_exp = '{11, 13, 7, 15, 8};
        for (int g = 0; g < 5; g++) in_data_c[g] = '0;
        build_sbox();
        expand(4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 0);
        expand(6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 1);
        expand(8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 2);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", 128'(ov[0]), 128'd0);
        check("rst_out_data", od[0], 128'd0);
        check("rst_out_tag", 128'(ot[0]), 128'd0);
        rst_n = 1'b1;
        #1 check("rst_in_ready", 128'(ir[0]), 128'd1);

        // Known-answer encrypt on all configurations, results held with out_ready low
        @(negedge clk);
        issue(1'b0, PT, 4'h3);
        wait_all();
        for (int g = 0; g < 5; g++) begin
            check($sformatf("enc_lat%0d", g), 128'(first[g]), 128'(lat_exp[g]));
            check($sformatf("enc_ct%0d", g), od[g], ct_exp[g]);
        end
        check("enc_tag", 128'(ot[0]), 128'h3);

        // Backpressure: 20 cycles in DONE with a competing input
        in_valid = 1'b1;
        in_data_c[0] = 128'hdeadbeef;
        in_tag = 4'hc;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_data", od[0], CT_A);
            check("bp_in_ready", 128'(ir[0]), 128'd0);
        end
        check("bp_valid", 128'(ov[0]), 128'd1);
        check("bp_tag", 128'(ot[0]), 128'h3);

        // Decrypt accepted in DONE together with out_ready
        in_decrypt = 1'b1;
        in_tag = 4'h5;
        for (int g = 0; g < 5; g++) in_data_c[g] = ct_exp[g];
        out_ready = 1'b1;
        #1 check("done_accept_ready", 128'(ir[0]), 128'd1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("done_accept_valid_drop", 128'(ov[0]), 128'd0);
        wait_all();
        for (int g = 0; g < 5; g++) begin
            check($sformatf("dec_lat%0d", g), 128'(first[g]), 128'(lat_exp[g]));
            check($sformatf("dec_pt%0d", g), od[g], PT);
        end
        check("dec_tag", 128'(ot[0]), 128'h5);
        out_ready = 1'b1;
        @(negedge clk);
        check("drain_idle_ready", 128'(ir[0]), 128'd1);

        // Back-to-back: continuous valid, alternating direction, tags 0..7
        nb = 0;
        nres = 0;
        last_c = 0;
        for (int c = 0; c < 200 && nres < 8; c++) begin
            @(negedge clk);
            if (ov[0]) begin
                check($sformatf("b2b_tag%0d", nres), 128'(ot[0]), 128'(nres));
                check($sformatf("b2b_data%0d", nres), od[0], (nres % 2 == 1) ? PT : CT_A);
                if (nres > 0) check("b2b_interval", 128'(c - last_c), 128'd11);
                last_c = c;
                nres++;
            end
            if (nb < 8) begin
                in_valid     = 1'b1;
                in_decrypt   = (nb % 2 == 1);
                in_tag       = 4'(nb);
                in_data_c[0] = (nb % 2 == 1) ? CT_A : PT;
                #1;
                if (ir[0]) nb++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("b2b_count", 128'(nres), 128'd8);

        // Flush at round 5 with a simultaneous input
        out_ready = 1'b0;
        @(negedge clk);
        issue(1'b0, PT, 4'h6);
        repeat (5) @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        #1 check("flush_in_ready", 128'(ir[0]), 128'd0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1 check("flush_ready_after", 128'(ir[0]), 128'd1);
        hits = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (ov[0]) hits++;
        end
        check("flush_no_output", 128'(hits), 128'd0);
        issue(1'b1, CT_A, 4'h9);
        wait_out(lat);
        check("post_flush_lat", 128'(lat), 128'd11);
        check("post_flush_pt", od[0], PT);
        check("post_flush_tag", 128'(ot[0]), 128'h9);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Async reset mid-RUN
        issue(1'b0, PT, 4'h2);
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check("rstrun_valid", 128'(ov[0]), 128'd0);
        check("rstrun_data", od[0], 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rstrun_ready", 128'(ir[0]), 128'd1);
        hits = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (ov[0]) hits++;
        end
        check("rstrun_no_output", 128'(hits), 128'd0);

        // Async reset mid-DONE
        issue(1'b0, PT, 4'ha);
        wait_out(lat);
        check("rstdone_ct", od[0], CT_A);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check("rstdone_valid", 128'(ov[0]), 128'd0);
        check("rstdone_data", od[0], 128'd0);
        check("rstdone_tag", 128'(ot[0]), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rstdone_ready", 128'(ir[0]), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
